// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and the JK-style update function for reg_bank_arbiter.
// apply_op works on a DATA_W_MAX-bit word; callers zero-extend and truncate (DATA_W <= 64).
package reg_bank_arbiter_pkg;

  localparam int DATA_W_MAX = 64;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_APPLY
  } state_t;

  function automatic logic [DATA_W_MAX-1:0] apply_op(
    input op_t                   op,
    input logic [DATA_W_MAX-1:0] old_val,
    input logic [DATA_W_MAX-1:0] d
  );
    apply_op = d;
    case (op)
      OP_LOAD:   apply_op = d;
      OP_SET:    apply_op = old_val | d;
      OP_CLEAR:  apply_op = old_val & ~d;
      OP_TOGGLE: apply_op = old_val ^ d;
      default:   apply_op = d;
    endcase
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid requester is assigned last.
  always_comb begin
    winner    = '0;
    any_valid = |valid;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (valid[j] && (j == ((int'(ptr) + off) % NUM_REQ))) begin
          winner = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that serialises requester operations onto a shared register bank.
// Optional err output enabled by defining REG_BANK_ARBITER_ERR_EN.
module reg_bank_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_REGS = 4,
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 2,
  localparam int GRANT_W  = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*2-1:0]         req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [GRANT_W-1:0]           grant_id,
  output logic                         busy,
`ifdef REG_BANK_ARBITER_ERR_EN
  output logic                         done,
  output logic                         err
`else
  output logic                         done
`endif
);

  import reg_bank_arbiter_pkg::*;

  state_t              state, state_nxt;
  logic [GRANT_W-1:0]  ptr;
  logic [GRANT_W-1:0]  pick;
  logic                any_valid;
  op_t                 hold_op;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic [DATA_W-1:0]   bank [NUM_REGS];
  logic                sel_valid;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                in_range;
  logic [DATA_W-1:0]   old_val;
  logic [DATA_W-1:0]   new_val;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .winner    (pick),
    .any_valid (any_valid)
  );

  // Mux the granted requester's fields using constant slices only.
  always_comb begin
    sel_valid = 1'b0;
    sel_op    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        sel_valid = req_valid[i];
        sel_op    = req_op[2*i +: 2];
        sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        sel_data  = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign in_range = (32'(hold_addr) < NUM_REGS);

  always_comb begin
    old_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hold_addr == ADDR_W'(k)) old_val = bank[k];
    end
  end

  assign new_val = DATA_W'(apply_op(hold_op, DATA_W_MAX'(old_val), DATA_W_MAX'(hold_data)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE:    if (any_valid) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == GRANT_W'(i)) req_ready[i] = 1'b1;
        end
        state_nxt = sel_valid ? ST_APPLY : ST_IDLE;
      end
      ST_APPLY:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // A dropped CAPTURE leaves ptr alone so the same requester keeps priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id  <= '0;
      ptr       <= '0;
      hold_op   <= OP_LOAD;
      hold_addr <= '0;
      hold_data <= '0;
      done      <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
    end else begin
      done <= (state == ST_APPLY);
      case (state)
        ST_IDLE: if (any_valid) grant_id <= pick;
        ST_CAPTURE: begin
          if (sel_valid) begin
            hold_op   <= op_t'(sel_op);
            hold_addr <= sel_addr;
            hold_data <= sel_data;
          end
        end
        ST_APPLY: begin
          ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (in_range && (hold_addr == ADDR_W'(k))) bank[k] <= new_val;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REG_BANK_ARBITER_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= ((state == ST_CAPTURE) && !sel_valid) || ((state == ST_APPLY) && !in_range);
  end
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
    assign reg_q[k*DATA_W +: DATA_W] = bank[k];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NUM_REGS=3 so address 3 is out of range).
// Checks err as well when REG_BANK_ARBITER_ERR_EN is defined.
module tb_reg_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 3;
  localparam int DW    = 32;
  localparam int AW    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*2-1:0]    req_op;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREGS*DW-1:0]  reg_q;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 done;
`ifdef REG_BANK_ARBITER_ERR_EN
  logic                 err;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [NREGS];
  int mptr;

  reg_bank_arbiter #(
    .NUM_REQ  (NREQ),
    .NUM_REGS (NREGS),
    .DATA_W   (DW),
    .ADDR_W   (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .reg_q     (reg_q),
    .grant_id  (grant_id),
    .busy      (busy),
`ifdef REG_BANK_ARBITER_ERR_EN
    .done      (done),
    .err       (err)
`else
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [1:0] op, input logic [1:0] addr, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_op[i*2 +: 2]     = op;
    req_addr[i*AW +: AW] = addr;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREGS*DW-1:0] pack_mem();
    logic [NREGS*DW-1:0] v;
    for (int k = 0; k < NREGS; k++) v[k*DW +: DW] = mem[k];
    return v;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [1:0] a, input logic [DW-1:0] d);
    int ai;
    ai = int'(a);
    if (ai < NREGS) begin
      case (op)
        2'b00:   mem[ai] = d;
        2'b01:   mem[ai] = mem[ai] | d;
        2'b10:   mem[ai] = mem[ai] & ~d;
        default: mem[ai] = mem[ai] ^ d;
      endcase
    end
  endtask

  // Serve every currently valid request, checking each 3-cycle transaction against the model.
  task automatic run_ops(input string tag);
    int w;
    logic [1:0] op, a;
    logic [DW-1:0] d;
    logic [NREQ-1:0] oh;
    while (req_valid != '0) begin
      w  = model_pick();
      op = req_op[w*2 +: 2];
      a  = req_addr[w*AW +: AW];
      d  = req_data[w*DW +: DW];
      oh = '0;
      oh[w] = 1'b1;
      @(negedge clk);
      checkOutput({tag, " ready"}, 128'(req_ready), 128'(oh));
      checkOutput({tag, " grant_id"}, 128'(grant_id), 128'(w));
      checkOutput({tag, " busy_capture"}, 128'(busy), 128'(1));
      @(negedge clk);
      checkOutput({tag, " done_apply"}, 128'(done), 128'(0));
      req_valid[w] = 1'b0;
      model_apply(op, a, d);
      mptr = (w + 1) % NREQ;
      @(negedge clk);
      checkOutput({tag, " done"}, 128'(done), 128'(1));
      checkOutput({tag, " reg_q"}, 128'(reg_q), 128'(pack_mem()));
      checkOutput({tag, " busy_idle"}, 128'(busy), 128'(0));
`ifdef REG_BANK_ARBITER_ERR_EN
      checkOutput({tag, " err"}, 128'(err), 128'(int'(a) >= NREGS));
`endif
    end
  endtask

  initial begin
    int r;
    logic [NREQ-1:0] m;
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    mptr      = 0;
    for (int k = 0; k < NREGS; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset reg_q", 128'(reg_q), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset done", 128'(done), 128'(0));
    checkOutput("reset ready", 128'(req_ready), 128'(0));
    checkOutput("reset grant_id", 128'(grant_id), 128'(0));
    reset = 1'b0;

    $display("[TB] all requesters load their id into reg0");
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 2'b00, 2'd0, DW'(i));
    run_ops("all4");
    checkOutput("all4 reg0", 128'(reg_q[DW-1:0]), 128'(32'd3));

    $display("[TB] requester 0 op chain on reg2");
    applyStimulus(0, 2'b00, 2'd2, 32'h0000_00F0); run_ops("chain load");
    applyStimulus(0, 2'b01, 2'd2, 32'h0000_000F); run_ops("chain set");
    applyStimulus(0, 2'b10, 2'd2, 32'h0000_0030); run_ops("chain clear");
    applyStimulus(0, 2'b11, 2'd2, 32'hFFFF_0000); run_ops("chain toggle");
    checkOutput("chain reg2", 128'(reg_q[2*DW +: DW]), 128'(32'hFFFF_00CF));

    $display("[TB] pointer wrap after requester 2");
    applyStimulus(2, 2'b00, 2'd1, 32'h1234_5678); run_ops("wrap r2");
    applyStimulus(1, 2'b01, 2'd1, 32'h0000_0001);
    applyStimulus(3, 2'b11, 2'd1, 32'h8000_0000);
    @(negedge clk);
    checkOutput("wrap first winner", 128'(req_ready), 128'(4'b1000));
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 2'b01, 2'd1, 32'h0000_0001);
    applyStimulus(3, 2'b11, 2'd1, 32'h8000_0000);
    run_ops("wrap pair");

    $display("[TB] out-of-range address");
    applyStimulus(0, 2'b00, 2'd3, 32'hA5A5_A5A5); run_ops("oob");

    $display("[TB] withdraw during capture");
    r = mptr;
    applyStimulus(r, 2'b00, 2'd0, 32'h0BAD_F00D);
    @(negedge clk);
    checkOutput("drop ready", 128'(req_ready[r]), 128'(1));
    req_valid[r] = 1'b0;
    @(negedge clk);
    checkOutput("drop busy", 128'(busy), 128'(0));
    checkOutput("drop done", 128'(done), 128'(0));
    checkOutput("drop reg_q", 128'(reg_q), 128'(pack_mem()));
`ifdef REG_BANK_ARBITER_ERR_EN
    checkOutput("drop err", 128'(err), 128'(1));
`endif
    applyStimulus(r, 2'b00, 2'd0, 32'h0BAD_F00D);
    applyStimulus((r + 1) % NREQ, 2'b11, 2'd2, 32'h0000_FFFF);
    run_ops("drop retry");

    $display("[TB] randomized rounds");
    for (int n = 0; n < 12; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (m[i]) applyStimulus(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      end
      run_ops("random");
    end

    $display("[TB] reset during apply");
    applyStimulus(2, 2'b00, 2'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("rst ready", 128'(req_ready), 128'(4'b0100));
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    #1;
    checkOutput("rst mid reg_q", 128'(reg_q), 128'(0));
    checkOutput("rst mid busy", 128'(busy), 128'(0));
    checkOutput("rst mid grant_id", 128'(grant_id), 128'(0));
    checkOutput("rst mid done", 128'(done), 128'(0));
    for (int k = 0; k < NREGS; k++) mem[k] = '0;
    mptr = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst after reg_q", 128'(reg_q), 128'(0));
    checkOutput("rst after done", 128'(done), 128'(0));
    applyStimulus(1, 2'b01, 2'd0, 32'h0000_00FF);
    applyStimulus(3, 2'b00, 2'd1, 32'h0000_1111);
    run_ops("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
